// File: rtl/bcd_alarm_clock_if.sv
// bcd_alarm_clock_if
//   Bundles the button-side controls and the display-side outputs of the
//   time-of-day clock.
//   master : button front-end / display driver (drives controls, reads time)
//   slave  : the clock itself
//   mode[1:0]  00 RUN, 01 SET_TIME, 10 SET_ALARM, 11 RUN
//   turn       next field in set modes, silence alert in RUN (1-cycle pulse)
//   change     increment field in set modes, toggle arm in RUN (1-cycle pulse)
//   reset1     clear seconds and prescaler (1-cycle pulse)
//   hour/minute/second  BCD display value
//   sel[1:0]   selected field 00 HOUR, 01 MIN, 10 SEC
//   armed, alert, tick  status outputs
interface bcd_alarm_clock_if;
    logic [1:0] mode;
    logic       turn;
    logic       change;
    logic       reset1;
    logic [7:0] hour;
    logic [7:0] minute;
    logic [7:0] second;
    logic [1:0] sel;
    logic       armed;
    logic       alert;
    logic       tick;

    modport master (
        output mode, turn, change, reset1,
        input  hour, minute, second, sel, armed, alert, tick
    );

    modport slave (
        input  mode, turn, change, reset1,
        output hour, minute, second, sel, armed, alert, tick
    );
endinterface

// File: rtl/bcd_alarm_clock.sv
// bcd_alarm_clock
//   Time-of-day clock: 1 Hz prescaler, BCD hh:mm:ss counter, field-set FSM,
//   hourly chime and optional armed alarm driving a registered alert output.
//   Optional feature macro: CLOCK_ALARM_EN (alarm registers, arm toggle and
//   SET_ALARM mode). Without it mode 10 behaves as RUN and armed is 0.
// Ports
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    bcd_alarm_clock_if.slave (controls in, display/status out)
// Parameters
//   CLK_DIV     clk cycles per second tick (>=2)
//   DIV_W       prescaler width, 2**DIV_W >= CLK_DIV
//   ALERT_SECS  alert window length in seconds (1..59)
module bcd_alarm_clock #(
    parameter int unsigned CLK_DIV    = 50000000,
    parameter int unsigned DIV_W      = 26,
    parameter int unsigned ALERT_SECS = 5
) (
    input  logic               clk,
    input  logic               reset,
    bcd_alarm_clock_if.slave   bus
);

    typedef enum logic [1:0] {
        SEL_HOUR = 2'b00,
        SEL_MIN  = 2'b01,
        SEL_SEC  = 2'b10
    } sel_t;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    sel_t             sel_q, sel_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [7:0]       hr_q, hr_d, mn_q, mn_d, sc_q, sc_d;
    logic [1:0]       mode_q;
    logic             sil_q, sil_d, alert_q, alert_d;
`ifdef CLOCK_ALARM_EN
    logic [7:0]       al_hr_q, al_hr_d, al_mn_q, al_mn_d;
    logic             armed_q, armed_d;
`endif

    logic mode_chg, set_time, set_alarm, run_mode, edit, adv, in_window, cond;

    // Wrapping BCD increment; last is the final legal value (8'h59 / 8'h23).
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
        if (v == last)
            return '0;
        else if (v[3:0] == 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [6:0] bcd_bin(input logic [7:0] v);
        return 7'(v[7:4]) * 7'd10 + 7'(v[3:0]);
    endfunction

    assign mode_chg = (bus.mode != mode_q);
    assign set_time = (bus.mode == 2'b01);
`ifdef CLOCK_ALARM_EN
    assign set_alarm = (bus.mode == 2'b10);
`else
    assign set_alarm = 1'b0;
`endif
    assign run_mode = !set_time && !set_alarm;
    // turn has priority over change; a mode-change cycle only re-homes sel.
    assign edit = bus.change && !bus.turn && !mode_chg;
    // reset1 beats the carry, so a coincident wrap produces no advance.
    assign adv  = (div_q == DIV_LAST) && !set_time && !bus.reset1;

    assign in_window = (bcd_bin(sc_q) < 7'(ALERT_SECS));
`ifdef CLOCK_ALARM_EN
    assign cond = in_window && ((mn_q == 8'h00) ||
                  (armed_q && hr_q == al_hr_q && mn_q == al_mn_q));
`else
    assign cond = in_window && (mn_q == 8'h00);
`endif

    // Field-select FSM
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sel_q <= SEL_HOUR;
        else        sel_q <= sel_d;
    end

    always_comb begin
        sel_d = sel_q;
        if (mode_chg || run_mode) begin
            sel_d = SEL_HOUR;
        end else if (bus.turn) begin
            if (set_time) begin
                case (sel_q)
                    SEL_HOUR: sel_d = SEL_MIN;
                    SEL_MIN:  sel_d = SEL_SEC;
                    default:  sel_d = SEL_HOUR;
                endcase
            end else begin
                sel_d = (sel_q == SEL_HOUR) ? SEL_MIN : SEL_HOUR;
            end
        end
    end

    // Datapath next state
    always_comb begin
        hr_d  = hr_q;
        mn_d  = mn_q;
        sc_d  = sc_q;
        div_d = (set_time || bus.reset1 || div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        if (adv) begin
            sc_d = bcd_inc(sc_q, 8'h59);
            if (sc_q == 8'h59) begin
                mn_d = bcd_inc(mn_q, 8'h59);
                if (mn_q == 8'h59) hr_d = bcd_inc(hr_q, 8'h23);
            end
        end
        if (set_time && edit) begin
            case (sel_q)
                SEL_HOUR: hr_d = bcd_inc(hr_q, 8'h23);
                SEL_MIN:  mn_d = bcd_inc(mn_q, 8'h59);
                default:  sc_d = bcd_inc(sc_q, 8'h59);
            endcase
        end
        if (bus.reset1) sc_d = '0;

        // Silence persists only while the window condition holds.
        sil_d   = cond && (sil_q || (run_mode && bus.turn && alert_q));
        alert_d = cond && !sil_d;
    end

`ifdef CLOCK_ALARM_EN
    always_comb begin
        al_hr_d = al_hr_q;
        al_mn_d = al_mn_q;
        armed_d = armed_q ^ (run_mode && edit);
        if (set_alarm && edit) begin
            if (sel_q == SEL_HOUR) al_hr_d = bcd_inc(al_hr_q, 8'h23);
            else                   al_mn_d = bcd_inc(al_mn_q, 8'h59);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            al_hr_q <= '0;
            al_mn_q <= '0;
            armed_q <= 1'b0;
        end else begin
            al_hr_q <= al_hr_d;
            al_mn_q <= al_mn_d;
            armed_q <= armed_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q   <= '0;
            hr_q    <= '0;
            mn_q    <= '0;
            sc_q    <= '0;
            mode_q  <= 2'b00;
            sil_q   <= 1'b0;
            alert_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            hr_q    <= hr_d;
            mn_q    <= mn_d;
            sc_q    <= sc_d;
            mode_q  <= bus.mode;
            sil_q   <= sil_d;
            alert_q <= alert_d;
        end
    end

    // Display mux: SET_ALARM shows the alarm time with seconds blanked to 00.
    always_comb begin
        bus.hour   = hr_q;
        bus.minute = mn_q;
        bus.second = sc_q;
`ifdef CLOCK_ALARM_EN
        if (set_alarm) begin
            bus.hour   = al_hr_q;
            bus.minute = al_mn_q;
            bus.second = 8'h00;
        end
`endif
    end

    assign bus.sel   = sel_q;
    assign bus.alert = alert_q;
    assign bus.tick  = adv;
`ifdef CLOCK_ALARM_EN
    assign bus.armed = armed_q;
`else
    assign bus.armed = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// tb_bcd_alarm_clock
//   Self-checking bench for bcd_alarm_clock (CLK_DIV=4, ALERT_SECS=2).
//   The reference keeps time as seconds-of-day and the alarm as
//   minutes-of-day; BCD only appears when comparing against the display.
module tb_bcd_alarm_clock;

`ifdef CLOCK_ALARM_EN
    localparam bit ALARM = 1'b1;
`else
    localparam bit ALARM = 1'b0;
`endif
    localparam int unsigned DIV = 4;
    localparam int unsigned AS  = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bcd_alarm_clock_if bus();

    bcd_alarm_clock #(.CLK_DIV(DIV), .DIV_W(2), .ALERT_SECS(AS)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;
    int unsigned tick_cnt = 0;

    // reference state
    int unsigned m_t, m_div, m_sel, m_alm, m_prev;
    bit          m_armed, m_sil, m_alert;

    function automatic logic [7:0] to_bcd(input int unsigned v);
        logic [3:0] t, u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_total++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int unsigned hms();
        return {8'h00, bus.hour, bus.minute, bus.second};
    endfunction

    task automatic model_reset();
        m_t = 0; m_div = 0; m_sel = 0; m_alm = 0; m_prev = 0;
        m_armed = 0; m_sil = 0; m_alert = 0;
    endtask

    task automatic compare_cycle();
        bit st, sa, tk;
        st = (bus.mode == 2'b01);
        sa = ALARM && (bus.mode == 2'b10);
        tk = !st && (m_div == DIV - 1) && !bus.reset1;
        if (sa) begin
            check("hour",   bus.hour,   to_bcd(m_alm / 60));
            check("minute", bus.minute, to_bcd(m_alm % 60));
            check("second", bus.second, 8'h00);
        end else begin
            check("hour",   bus.hour,   to_bcd(m_t / 3600));
            check("minute", bus.minute, to_bcd((m_t / 60) % 60));
            check("second", bus.second, to_bcd(m_t % 60));
        end
        check("sel",   bus.sel,   m_sel);
        check("armed", bus.armed, m_armed);
        check("alert", bus.alert, m_alert);
        check("tick",  bus.tick,  tk);
    endtask

    task automatic model_next();
        int unsigned s, mi, h;
        bit st, sa, run, chg, edit, win, cond;
        st   = (bus.mode == 2'b01);
        sa   = ALARM && (bus.mode == 2'b10);
        run  = !st && !sa;
        chg  = (bus.mode != m_prev);
        s    = m_t % 60;
        mi   = (m_t / 60) % 60;
        h    = m_t / 3600;
        win  = (s < AS);
        cond = win && (mi == 0 || (m_armed && (m_t / 60) == m_alm));
        edit = bus.change && !bus.turn && !chg;

        if (!st && m_div == DIV - 1 && !bus.reset1) m_t = (m_t + 1) % 86400;
        if (st && edit) begin
            case (m_sel)
                0: m_t = ((h + 1) % 24) * 3600 + mi * 60 + s;
                1: m_t = h * 3600 + ((mi + 1) % 60) * 60 + s;
                default: m_t = h * 3600 + mi * 60 + (s + 1) % 60;
            endcase
        end
        if (bus.reset1) m_t = m_t - (m_t % 60);
        m_div = (st || bus.reset1 || m_div == DIV - 1) ? 0 : m_div + 1;

        if (sa && edit) begin
            if (m_sel == 0) m_alm = (((m_alm / 60) + 1) % 24) * 60 + m_alm % 60;
            else            m_alm = (m_alm / 60) * 60 + ((m_alm % 60) + 1) % 60;
        end
        if (ALARM && run && edit) m_armed = !m_armed;

        if (chg || run)          m_sel = 0;
        else if (bus.turn && st) m_sel = (m_sel + 1) % 3;
        else if (bus.turn)       m_sel = (m_sel == 0) ? 1 : 0;

        if (!cond) begin
            m_sil = 0;
            m_alert = 0;
        end else begin
            if (run && bus.turn && m_alert) m_sil = 1;
            m_alert = !m_sil;
        end
        m_prev = bus.mode;
    endtask

    // One clock: drive inputs, compare at negedge, advance reference, return at posedge+1.
    task automatic step(input logic [1:0] m, input bit tu, input bit ch, input bit r1);
        bus.mode = m; bus.turn = tu; bus.change = ch; bus.reset1 = r1;
        @(negedge clk);
        compare_cycle();
        if (bus.tick) tick_cnt++;
        model_next();
        @(posedge clk);
        #1;
        bus.turn = 1'b0; bus.change = 1'b0; bus.reset1 = 1'b0;
    endtask

    task automatic do_reset();
        bus.turn = 1'b0; bus.change = 1'b0; bus.reset1 = 1'b0;
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_time",  hms(), 0);
        check("rst_sel",   bus.sel, 0);
        check("rst_alert", bus.alert, 0);
        check("rst_armed", bus.armed, 0);
        check("rst_tick",  bus.tick, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Leaves the clock in SET_TIME with sel=SEC.
    task automatic set_time(input int unsigned h, input int unsigned mi, input int unsigned s);
        do_reset();
        step(2'b01, 0, 0, 0);
        repeat (h)  step(2'b01, 0, 1, 0);
        step(2'b01, 1, 0, 0);
        repeat (mi) step(2'b01, 0, 1, 0);
        step(2'b01, 1, 0, 0);
        repeat (s)  step(2'b01, 0, 1, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t0, cnt;
        bit found;
        bus.mode = 2'b00; bus.turn = 1'b0; bus.change = 1'b0; bus.reset1 = 1'b0;
        model_reset();
        #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: reset mid-run, then one minute of RUN
        repeat (37) step(2'b00, 0, 0, 0);
        do_reset();
        t0 = tick_cnt;
        repeat (240) step(2'b00, 0, 0, 0);
        check("t1_time",  hms(), 24'h000100);
        check("t1_ticks", tick_cnt - t0, 60);

        // 2: midnight rollover and chime window
        set_time(23, 59, 58);
        repeat (8) step(2'b00, 0, 0, 0);
        check("t2_time",  hms(), 24'h000000);
        check("t2_alert0", bus.alert, 0);
        cnt = 0;
        repeat (10) begin
            step(2'b00, 0, 0, 0);
            if (bus.alert) cnt++;
        end
        check("t2_alert_cycles", cnt, 8);

        // 3: field wrap without carry, frozen time in SET_TIME
        set_time(5, 59, 0);
        step(2'b01, 1, 0, 0);
        step(2'b01, 1, 0, 0);
        check("t3_sel", bus.sel, 1);
        step(2'b01, 0, 1, 0);
        check("t3_wrap", hms(), 24'h050000);
        t0 = tick_cnt;
        repeat (100) step(2'b01, 0, 0, 0);
        check("t3_ticks", tick_cnt - t0, 0);
        check("t3_frozen", hms(), 24'h050000);

        // 4: reset1 coincident with the wrap at second 59
        set_time(0, 5, 59);
        repeat (3) step(2'b00, 0, 0, 0);
        step(2'b00, 0, 0, 1);
        check("t4_reset1", hms(), 24'h000500);
        repeat (4) step(2'b00, 0, 0, 0);
        check("t4_next", hms(), 24'h000501);

        // 5/6: alarm at 00:01, arm, silence
        set_time(0, 0, 50);
        step(2'b10, 0, 0, 0);
        step(2'b10, 1, 0, 0);
        step(2'b10, 0, 1, 0);
        if (ALARM) check("t5_alarm_disp", hms(), 24'h000100);
        step(2'b00, 0, 0, 0);
        step(2'b00, 0, 1, 0);
        check("t5_armed", bus.armed, ALARM);
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            step(2'b00, 0, 0, 0);
            if (bus.minute == 8'h01) found = 1;
        end
        check("t5_reach_0100", found, 1);
        check("t5_time", hms(), 24'h000100);
        check("t5_alert_pre", bus.alert, 0);
        step(2'b00, 0, 0, 0);
        check("t5_alert_on", bus.alert, ALARM);
        step(2'b00, 1, 0, 0);
        check("t5_silenced", bus.alert, 0);
        cnt = 0;
        repeat (8) begin
            step(2'b00, 0, 0, 0);
            if (bus.alert) cnt++;
        end
        check("t5_stay_quiet", cnt, 0);

        set_time(0, 2, 0);
        repeat (8) step(2'b10, 0, 0, 0);
        check("t6_mode10", hms(), ALARM ? 24'h000000 : 24'h000202);

        // randomized traffic against the reference
        set_time(23, 59, 20);
        for (int i = 0; i < 4000; i++) begin
            logic [1:0] m;
            m = bus.mode;
            if ($urandom_range(0, 39) == 0) m = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1499) == 0) do_reset();
            step(m, $urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 96) == 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
